// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-style control FSM with memory-wait timeout trap
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic [3:0] state_o,
    output logic       retire_o,
    output logic       error_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        IMM_EXEC = 4'd8,
        IMM_WB   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JR       = 4'd12,
        TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          waiting, timeout;

    assign state_o = state;
    assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeout = (MEM_TIMEOUT > 0) && !mem_ready_i && (wait_cnt == WAIT_LAST);

    // state register and memory-wait counter; counter restarts on every state change
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state_nx != state) ? '0 :
                        (waiting && !mem_ready_i) ? wait_cnt + 1'b1 : wait_cnt;
        end
    end

    // next-state and control outputs; anything not set for a state stays 0
    always_comb begin
        state_nx     = state;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        pc_source_o  = 2'b00;
        retire_o     = 1'b0;
        error_o      = 1'b0;
        case (state)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                state_nx    = mem_ready_i ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                case (op_i)
                    OP_RTYPE:      state_nx = (funct_i == FN_JR) ? JR : EXEC;
                    OP_LW, OP_SW:  state_nx = MEM_ADDR;
                    OP_ADDI, OP_SLTI: state_nx = IMM_EXEC;
                    OP_BEQ, OP_BNE: state_nx = BRANCH;
                    OP_J, OP_JAL:  state_nx = JUMP;
                    default:       state_nx = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_nx    = (op_i == OP_LW) ? MEM_RD : (op_i == OP_SW) ? MEM_WR : TRAP;
            end
            MEM_RD: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
                state_nx   = mem_ready_i ? MEM_WB : timeout ? TRAP : MEM_RD;
            end
            MEM_WB: begin
                mem_to_reg_o = 2'b01;
                reg_write_o  = 1'b1;
                retire_o     = 1'b1;
                state_nx     = FETCH;
            end
            MEM_WR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
                retire_o    = mem_ready_i;
                state_nx    = mem_ready_i ? FETCH : timeout ? TRAP : MEM_WR;
            end
            EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b010;
                state_nx    = ALU_WB;
            end
            ALU_WB: begin
                reg_dst_o   = 2'b01;
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                state_nx    = FETCH;
            end
            IMM_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (op_i == OP_SLTI) ? 3'b011 : 3'b000;
                state_nx    = IMM_WB;
            end
            IMM_WB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                state_nx    = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b001;
                pc_source_o = 2'b01;
                pc_write_o  = (op_i == OP_BEQ) ? zero_i : (op_i == OP_BNE) ? ~zero_i : 1'b0;
                retire_o    = 1'b1;
                state_nx    = FETCH;
            end
            JUMP: begin
                pc_source_o  = 2'b10;
                pc_write_o   = 1'b1;
                reg_write_o  = (op_i == OP_JAL);
                reg_dst_o    = (op_i == OP_JAL) ? 2'b10 : 2'b00;
                mem_to_reg_o = (op_i == OP_JAL) ? 2'b10 : 2'b00;
                retire_o     = 1'b1;
                state_nx     = FETCH;
            end
            JR: begin
                pc_source_o = 2'b11;
                pc_write_o  = 1'b1;
                retire_o    = 1'b1;
                state_nx    = FETCH;
            end
            TRAP: begin
                error_o  = 1'b1;
                state_nx = TRAP;
            end
            default: state_nx = TRAP;
        endcase
    end
endmodule
